// File: rtl/stats_accum.sv
// stats_accum: per-channel Welford running mean/variance over MATRIX_SIZE lanes.
// Optional STATS_ACCUM_UNBIASED_EN: variance divides by n-1 (sample variance) instead of n.
module stats_accum #(
  parameter int DATA_WIDTH  = 15,
  parameter int FRAC_BITS   = 16,
  parameter int MATRIX_SIZE = 4,
  parameter int MAX_SAMPLES = 1024,
  localparam int W  = 1 + DATA_WIDTH + FRAC_BITS,
  localparam int CW = $clog2(MAX_SAMPLES + 1),
  localparam int TW = 2*W + $clog2(MATRIX_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [MATRIX_SIZE-1:0][W-1:0]  x_matrix,
  input  logic                           compute_variance,
  output logic                           valid_out,
  output logic [MATRIX_SIZE-1:0][2*W-1:0] variance,
  output logic [TW-1:0]                  total_variance
);
  localparam int KW = $clog2(2*W);

  typedef enum logic [2:0] {IDLE, DELTA, DIV, MEAN, M2UPD, VDIV, VSUM, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] n_q, n_d, dv;
  logic [KW-1:0] cnt_q, cnt_d;
  logic          valid_out_q, valid_out_d;
  logic [TW-1:0] total_q, total_d;
  logic          accept_s, accept_v, dv_zero;
  logic [MATRIX_SIZE-1:0][2*W-1:0] vres;

  assign accept_s = valid_in && (n_q != CW'(MAX_SAMPLES));
  assign accept_v = !valid_in && compute_variance;

  // One shared divisor feeds every lane's restoring divider.
`ifdef STATS_ACCUM_UNBIASED_EN
  assign dv = ((state inside {VDIV, VSUM}) && n_q != '0) ? n_q - CW'(1) : n_q;
`else
  assign dv = n_q;
`endif
  assign dv_zero = (dv == '0);

  always_comb begin
    state_d     = state;
    n_d         = n_q;
    cnt_d       = cnt_q + KW'(1);
    valid_out_d = 1'b0;
    total_d     = total_q;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept_s)      state_d = DELTA;
        else if (accept_v) state_d = VDIV;
      end
      DELTA: begin
        n_d     = n_q + CW'(1);
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV:   if (cnt_q == KW'(W-1)) state_d = MEAN;
      MEAN:  state_d = M2UPD;
      M2UPD: state_d = IDLE;
      VDIV:  if (cnt_q == KW'(2*W-1)) state_d = VSUM;
      VSUM: begin
        total_d = '0;
        for (int i = 0; i < MATRIX_SIZE; i++)
          total_d = total_d + {{(TW-2*W){vres[i][2*W-1]}}, vres[i]};
        state_d = DONE;
      end
      DONE: begin
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      valid_out_q <= 1'b0;
      total_q     <= '0;
    end else begin
      state       <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      total_q     <= total_d;
    end

  assign valid_out      = valid_out_q;
  assign total_variance = total_q;

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [W-1:0]   x_q, x_d, mean_q, mean_d, delta_q, delta_d, q_w, d2;
    logic [2*W-1:0] m2_q, m2_d, dvd_q, dvd_d, var_q, var_d, prod;
    logic [CW-1:0]  rem_q, rem_d;
    logic [CW:0]    sh;
    logic           neg_q, neg_d, qbit;

    // dvd holds the left-aligned magnitude; quotient bits shift in from the bottom.
    assign sh      = {rem_q, dvd_q[2*W-1]};
    assign qbit    = (sh >= {1'b0, dv});
    assign q_w     = neg_q ? -dvd_q[W-1:0] : dvd_q[W-1:0];
    assign vres[i] = dv_zero ? '0 : (neg_q ? -dvd_q : dvd_q);
    assign d2      = x_q - mean_q;
    assign prod    = {{W{delta_q[W-1]}}, delta_q} * {{W{d2[W-1]}}, d2};

    always_comb begin
      x_d     = x_q;
      mean_d  = mean_q;
      delta_d = delta_q;
      m2_d    = m2_q;
      var_d   = var_q;
      neg_d   = neg_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      case (state)
        IDLE: begin
          if (accept_s) x_d = x_matrix[i];
          else if (accept_v) begin
            neg_d = m2_q[2*W-1];
            dvd_d = m2_q[2*W-1] ? -m2_q : m2_q;
            rem_d = '0;
          end
        end
        DELTA: begin
          delta_d = x_q - mean_q;
          neg_d   = delta_d[W-1];
          dvd_d   = {(delta_d[W-1] ? -delta_d : delta_d), {W{1'b0}}};
          rem_d   = '0;
        end
        DIV, VDIV: begin
          rem_d = qbit ? CW'(sh - {1'b0, dv}) : sh[CW-1:0];
          dvd_d = {dvd_q[2*W-2:0], qbit};
        end
        MEAN:  mean_d = mean_q + q_w;
        M2UPD: m2_d   = m2_q + prod;
        VSUM:  var_d  = vres[i];
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        x_q     <= '0;
        mean_q  <= '0;
        delta_q <= '0;
        m2_q    <= '0;
        dvd_q   <= '0;
        rem_q   <= '0;
        neg_q   <= 1'b0;
        var_q   <= '0;
      end else begin
        x_q     <= x_d;
        mean_q  <= mean_d;
        delta_q <= delta_d;
        m2_q    <= m2_d;
        dvd_q   <= dvd_d;
        rem_q   <= rem_d;
        neg_q   <= neg_d;
        var_q   <= var_d;
      end

    assign variance[i] = var_q;
  end
endmodule

// File: tb/tb_stats_accum.sv
// Bench for stats_accum: transaction-level Welford model checked every cycle,
// plus directed literal checks (reset, 11.25 example, negatives, aborts, sample limit).
module tb_stats_accum;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int MAXS = 1024;
  localparam int TW   = 2*W + $clog2(N);

  logic clk = 1'b0, rst_n = 1'b1;
  logic valid_in = 1'b0, compute_variance = 1'b0;
  logic [N-1:0][W-1:0] x_matrix = '0;
  logic valid_out;
  logic [N-1:0][2*W-1:0] variance;
  logic [TW-1:0] total_variance;

  logic valid_in2 = 1'b0, compute2 = 1'b0, valid_out2;
  logic [N-1:0][W-1:0] x2 = '0;
  logic [N-1:0][2*W-1:0] variance2;
  logic [TW-1:0] total2;

  int errors = 0, checks = 0, vo_cnt = 0;

  always #5 clk = ~clk;

  stats_accum dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .x_matrix(x_matrix),
    .compute_variance(compute_variance), .valid_out(valid_out),
    .variance(variance), .total_variance(total_variance));

  stats_accum #(.MAX_SAMPLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in2), .x_matrix(x2),
    .compute_variance(compute2), .valid_out(valid_out2),
    .variance(variance2), .total_variance(total2));

  // Reference: statistics per the Welford rules, timing as accept-to-result latencies.
  int     m_mean [N];
  longint m_m2   [N];
  int     m_n = 0, busy = 0;
  bit     is_var = 0, exp_valid = 0;
  logic [N-1:0][63:0] exp_var = '0, pend_var = '0;
  logic [TW-1:0] exp_total = '0, pend_total = '0;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real exp, input real tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %f expected %f", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; busy = 0; is_var = 0; exp_valid = 0; exp_var = '0; exp_total = '0;
    for (int i = 0; i < N; i++) begin m_mean[i] = 0; m_m2[i] = 0; end
  endtask

  task automatic model_step();
    logic signed [TW-1:0] tot;
    longint dvs, v;
    int d, q;
    if (!rst_n) return;
    exp_valid = 0;
    if (busy > 0) begin
      busy--;
      if (is_var && busy == 1) begin exp_var = pend_var; exp_total = pend_total; end
      if (is_var && busy == 0) exp_valid = 1;
    end else if (valid_in) begin
      if (m_n < MAXS) begin
        m_n++;
        for (int i = 0; i < N; i++) begin
          d = int'(x_matrix[i]) - m_mean[i];
          q = d / m_n;
          m_mean[i] = m_mean[i] + q;
          m_m2[i] = m_m2[i] + longint'(d) * longint'(int'(x_matrix[i]) - m_mean[i]);
        end
        busy = W + 3; is_var = 0;
      end
    end else if (compute_variance) begin
`ifdef STATS_ACCUM_UNBIASED_EN
      dvs = (m_n < 2) ? 0 : m_n - 1;
`else
      dvs = m_n;
`endif
      tot = '0;
      for (int i = 0; i < N; i++) begin
        v = (dvs == 0) ? 0 : m_m2[i] / dvs;
        pend_var[i] = v;
        tot = tot + TW'(v);
      end
      pend_total = tot; busy = 2*W + 2; is_var = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk); model_step(); @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (valid_out) vo_cnt++;
    chk("valid_out", TW'(valid_out), TW'(exp_valid));
    for (int i = 0; i < N; i++)
      chk($sformatf("variance[%0d]", i), TW'(variance[i]), TW'(exp_var[i]));
    chk("total_variance", total_variance, exp_total);
  end

  task automatic do_reset();
    #2 rst_n = 1'b0; model_reset();
    valid_in = 0; compute_variance = 0; valid_in2 = 0; compute2 = 0;
    tick(); tick();
    chk("rst_valid_out", TW'(valid_out), '0);
    for (int i = 0; i < N; i++) chk("rst_variance", TW'(variance[i]), '0);
    chk("rst_total", total_variance, '0);
    #2 rst_n = 1'b1;
  endtask

  task automatic send(input logic [N-1:0][W-1:0] x, input bit with_cmp, input bit poke);
    x_matrix = x; valid_in = 1; compute_variance = with_cmp;
    tick(); valid_in = 0; compute_variance = 0;
    for (int k = 0; k < W + 3; k++) begin
      if (poke && k == 10) begin
        valid_in = 1; compute_variance = 1; x_matrix = {N{32'h7fff0000}};
      end
      tick(); valid_in = 0; compute_variance = 0;
    end
  endtask

  task automatic compute_wait(input string nm);
    int c = 0;
    compute_variance = 1; tick(); compute_variance = 0;
    do begin tick(); c++; end while (!valid_out && c < 200);
    chk(nm, TW'(c), TW'(66));
  endtask

  function automatic logic [N-1:0][W-1:0] rep(input int v);
    return {N{W'(v)}};
  endfunction

  logic [W-1:0] ch0 [4] = '{32'h000A199A, 32'h0009199A, 32'h000A3333, 32'h000A3333};

  initial begin
    logic [N-1:0][W-1:0] xs;
    longint lv;
    real r;
    int c, vo0;
`ifdef STATS_ACCUM_UNBIASED_EN
    logic [63:0] v_main = 64'h0000000F_00000000, v_neg = 64'h00000008_00000000;
    logic [63:0] v_max = 64'h00000000_80000000;
    real v0 = 0.86 / 3.0, vt = 45.0 + 0.86 / 3.0;
`else
    logic [63:0] v_main = 64'h0000000B_40000000, v_neg = 64'h00000004_00000000;
    logic [63:0] v_max = 64'h00000000_40000000;
    real v0 = 0.215, vt = 33.965;
`endif
    #1 rst_n = 1'b0; model_reset();
    repeat (3) tick();
    do_reset();

    // Compute with no samples.
    compute_wait("empty_latency");
    for (int i = 0; i < N; i++) chk("empty_variance", TW'(variance[i]), '0);

    // Worked example, with a busy-time poke on one sample.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      xs[3] = W'((1 + 3*k) << 16);
      xs[2] = W'((2 + 3*k) << 16);
      xs[1] = W'((3 + 3*k) << 16);
      xs[0] = ch0[k];
      send(xs, 1'b0, k == 2);
    end
    compute_wait("example_latency");
    for (int i = 1; i < N; i++) begin
      chk($sformatf("example_var[%0d]", i), TW'(variance[i]), TW'(v_main));
      chk("model_pin_var", TW'(exp_var[i]), TW'(v_main));
    end
    lv = variance[0]; r = lv / 4294967296.0;
    chk_real("example_var0", r, v0, 1.0 / 16384.0);
    lv = total_variance[63:0]; r = lv / 4294967296.0;
    chk_real("example_total", r, vt, 1.0 / 4096.0);

    // Reset during DIV, then negatives (also valid_in+compute together).
    do_reset();
    x_matrix = rep(3 << 16); valid_in = 1; tick(); valid_in = 0;
    repeat (5) tick();
    do_reset();
    vo0 = vo_cnt;
    send(rep(-2 << 16), 1'b1, 1'b0);
    chk("sample_beats_compute", TW'(vo_cnt - vo0), '0);
    send(rep(2 << 16), 1'b0, 1'b0);
    compute_wait("neg_latency");
    for (int i = 0; i < N; i++) chk("neg_variance", TW'(variance[i]), TW'(v_neg));

    // Reset during VDIV, then compute must see n==0.
    compute_variance = 1; tick(); compute_variance = 0;
    repeat (20) tick();
    do_reset();
    compute_wait("post_vdiv_reset_latency");
    for (int i = 0; i < N; i++) chk("post_vdiv_reset_var", TW'(variance[i]), '0);

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      valid_in = ($urandom_range(0, 3) == 0);
      compute_variance = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++)
        x_matrix[i] = W'(int'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000);
      tick();
    end
    valid_in = 0; compute_variance = 0;
    repeat (70) tick();

    // Sample limit on the MAX_SAMPLES=2 instance.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      x2 = rep(k << 16); valid_in2 = 1; tick(); valid_in2 = 0;
      if (k < 3) repeat (W + 3) tick();
    end
    compute2 = 1; tick(); compute2 = 0;
    c = 0;
    do begin tick(); c++; end while (!valid_out2 && c < 200);
    chk("max_latency", TW'(c), TW'(66));
    for (int i = 0; i < N; i++) chk("max_variance", TW'(variance2[i]), TW'(v_max));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
